usb_data_packetizer: RTL and testbench

//  Transmit-side data-stage packetizer for the USB host controller: consumes one OUT transfer

---
 rtl/usb_data_packetizer_pkg.sv | 27 ++
 rtl/usb_data_packetizer_crc16.sv | 25 ++
 rtl/usb_data_packetizer.sv | 206 ++++++++++++++++++++
 tb/tb_usb_data_packetizer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_data_packetizer_pkg.sv
// rtl/usb_data_packetizer_pkg.sv - PID and CRC16 constants, packet FSM states, byte-wide CRC16 step
package usb_data_packetizer_pkg;

  localparam logic [7:0]  PID_DATA0    = 8'hC3;
  localparam logic [7:0]  PID_DATA1    = 8'h4B;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_DONE
  } pkt_state_e;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_data_packetizer_crc16.sv
// rtl/usb_data_packetizer_crc16.sv - running reflected CRC16 over payload bytes
module usb_data_packetizer_crc16
  import usb_data_packetizer_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_enable,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_crc <= CRC16_INIT;
    end else if (i_enable) begin
      r_crc <= crc16_byte(r_crc, i_data);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/usb_data_packetizer.sv
// rtl/usb_data_packetizer.sv - splits an OUT transfer into DATA0/DATA1 packets with CRC16
// USB_PKT_ZLP_EN: append a zero-length packet when the length is a nonzero multiple of MAX_PKT_BYTES
module usb_data_packetizer
  import usb_data_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH    = 64,
  parameter int MAX_PKT_BYTES = 512,
  parameter int LEN_WIDTH     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_desc_valid,
  output logic                  o_desc_ready,
  input  logic [LEN_WIDTH-1:0]  i_desc_length,
  input  logic                  i_desc_toggle,
  input  logic                  i_abort,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_sop,
  output logic                  o_tx_eop,
  output logic                  o_done,
  output logic                  o_next_toggle,
  output logic [15:0]           o_pkt_count,
  output logic                  o_busy
);

  localparam int PKT_W = $clog2(MAX_PKT_BYTES) + 1;
  localparam int IDX_W = $clog2(DATA_WIDTH / 8);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_BYTES);

  pkt_state_e            r_state;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [PKT_W-1:0]      r_pkt_left;
  logic                  r_toggle;
  logic                  r_zlp_pend;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_buf_valid;
  logic [IDX_W-1:0]      r_byte_idx;
  logic                  r_desc_ready;
  logic                  r_done;
  logic                  r_next_toggle;
  logic                  r_busy;
  logic [15:0]           r_pkt_count;

  logic                  w_tx_valid;
  logic [7:0]            w_tx_data;
  logic [7:0]            w_data_byte;
  logic [15:0]           w_crc;
  logic [PKT_W-1:0]      w_chunk;
  logic                  w_tx_fire;
  logic                  w_in_fire;
  logic                  w_desc_fire;
  logic                  w_zlp_req;

`ifdef USB_PKT_ZLP_EN
  localparam int LOG2_MAX = $clog2(MAX_PKT_BYTES);
  assign w_zlp_req = (i_desc_length != '0) && (i_desc_length[LOG2_MAX-1:0] == '0);
`else
  assign w_zlp_req = 1'b0;
`endif

  assign w_data_byte = r_buf[{r_byte_idx, 3'b000} +: 8];
  assign w_chunk     = (r_remaining > MAX_LEN) ? PKT_W'(MAX_PKT_BYTES) : PKT_W'(r_remaining);

  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = 8'h00;
    case (r_state)
      ST_PID: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_toggle ? PID_DATA1 : PID_DATA0;
      end
      ST_DATA: begin
        w_tx_valid = r_buf_valid;
        w_tx_data  = r_buf_valid ? w_data_byte : 8'h00;
      end
      ST_CRC_LO: begin
        w_tx_valid = 1'b1;
        w_tx_data  = ~w_crc[7:0];
      end
      ST_CRC_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = ~w_crc[15:8];
      end
      default: ;
    endcase
  end

  assign o_tx_valid    = w_tx_valid;
  assign o_tx_data     = w_tx_data;
  assign o_tx_sop      = (r_state == ST_PID);
  assign o_tx_eop      = (r_state == ST_CRC_HI);
  assign o_in_ready    = (r_state == ST_DATA) && !r_buf_valid;
  assign o_desc_ready  = r_desc_ready;
  assign o_done        = r_done;
  assign o_next_toggle = r_next_toggle;
  assign o_pkt_count   = r_pkt_count;
  assign o_busy        = r_busy;

  assign w_tx_fire   = w_tx_valid && i_tx_ready;
  assign w_in_fire   = o_in_ready && i_in_valid;
  assign w_desc_fire = i_desc_valid && r_desc_ready;

  usb_data_packetizer_crc16 u_crc (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  ((r_state == ST_PID) && w_tx_fire),
    .i_enable ((r_state == ST_DATA) && w_tx_fire),
    .i_data   (w_data_byte),
    .o_crc    (w_crc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_remaining   <= '0;
      r_pkt_left    <= '0;
      r_toggle      <= 1'b0;
      r_zlp_pend    <= 1'b0;
      r_buf         <= '0;
      r_buf_valid   <= 1'b0;
      r_byte_idx    <= '0;
      r_desc_ready  <= 1'b1;
      r_done        <= 1'b0;
      r_next_toggle <= 1'b0;
      r_busy        <= 1'b0;
      r_pkt_count   <= '0;
    end else if (i_abort) begin
      r_state      <= ST_IDLE;
      r_buf_valid  <= 1'b0;
      r_byte_idx   <= '0;
      r_zlp_pend   <= 1'b0;
      r_desc_ready <= 1'b1;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_in_fire) begin
        r_buf       <= i_in_data;
        r_buf_valid <= 1'b1;
        r_byte_idx  <= '0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_desc_fire) begin
            r_remaining  <= i_desc_length;
            r_toggle     <= i_desc_toggle;
            r_zlp_pend   <= w_zlp_req;
            r_pkt_count  <= '0;
            r_buf_valid  <= 1'b0;
            r_byte_idx   <= '0;
            r_desc_ready <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= ST_PID;
          end
        end
        ST_PID: begin
          if (w_tx_fire) begin
            r_pkt_left <= w_chunk;
            r_state    <= (w_chunk == '0) ? ST_CRC_LO : ST_DATA;
          end
        end
        ST_DATA: begin
          // a partially used word stays buffered into the next packet
          if (w_tx_fire) begin
            r_byte_idx  <= r_byte_idx + IDX_W'(1);
            r_pkt_left  <= r_pkt_left - PKT_W'(1);
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            if (r_byte_idx == '1) r_buf_valid <= 1'b0;
            if (r_pkt_left == PKT_W'(1)) r_state <= ST_CRC_LO;
          end
        end
        ST_CRC_LO: begin
          if (w_tx_fire) r_state <= ST_CRC_HI;
        end
        ST_CRC_HI: begin
          if (w_tx_fire) begin
            r_toggle    <= ~r_toggle;
            r_pkt_count <= r_pkt_count + 16'd1;
            if (r_remaining != '0) begin
              r_state <= ST_PID;
            end else if (r_zlp_pend) begin
              r_zlp_pend <= 1'b0;
              r_state    <= ST_PID;
            end else begin
              r_done        <= 1'b1;
              r_next_toggle <= ~r_toggle;
              r_state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_desc_ready <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_data_packetizer.sv
// tb/tb_usb_data_packetizer.sv - randomized self-checking bench with a packet-level reference model
module tb_usb_data_packetizer;

  localparam int MAXP = 512;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic [15:0] desc_length = '0;
  logic        desc_toggle = 1'b0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        tx_ready = 1'b0;
  logic        o_desc_ready, o_in_ready, o_tx_valid, o_tx_sop, o_tx_eop;
  logic        o_done, o_next_toggle, o_busy;
  logic [7:0]  o_tx_data;
  logic [15:0] o_pkt_count;

  int n_cmp = 0;
  int n_fail = 0;

  bit          rnd_ready = 1'b0;
  bit          rnd_gaps = 1'b0;
  logic [63:0] wq[$];
  logic [63:0] words_all[$];
  logic [7:0]  obs_b[$], exp_b[$];
  bit          obs_sop[$], obs_eop[$], exp_sop[$], exp_eop[$];
  int          words_read, done_cnt, stall_viol, exp_pkts;
  bit          exp_nt, last_nt;
  bit          prev_stall = 1'b0;
  logic [9:0]  prev_tx = '0;

  usb_data_packetizer dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_desc_valid (desc_valid),
    .o_desc_ready (o_desc_ready),
    .i_desc_length(desc_length),
    .i_desc_toggle(desc_toggle),
    .i_abort      (abort),
    .i_in_valid   (in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_data    (in_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (tx_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_sop     (o_tx_sop),
    .o_tx_eop     (o_tx_eop),
    .o_done       (o_done),
    .o_next_toggle(o_next_toggle),
    .o_pkt_count  (o_pkt_count),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  // DMA source, link sink and stream recorder; handshakes are judged just after the falling edge
  always @(negedge clk) begin
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (wq.size() > 0) begin
      in_valid = rnd_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = wq[0];
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
    #1;
    if (o_done) done_cnt++;
    if (!rst && !abort) begin
      if (prev_stall && (!o_tx_valid || {o_tx_sop, o_tx_eop, o_tx_data} !== prev_tx)) stall_viol++;
      if (in_valid && o_in_ready) begin
        words_read++;
        if (wq.size() > 0) void'(wq.pop_front());
      end
      if (o_tx_valid && tx_ready) begin
        obs_b.push_back(o_tx_data);
        obs_sop.push_back(o_tx_sop);
        obs_eop.push_back(o_tx_eop);
      end
      prev_stall = o_tx_valid && !tx_ready;
      prev_tx    = {o_tx_sop, o_tx_eop, o_tx_data};
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  task automatic push_exp(input logic [7:0] b, input bit sop, input bit eop);
    exp_b.push_back(b);
    exp_sop.push_back(sop);
    exp_eop.push_back(eop);
  endtask

  task automatic build_expected(input int len, input bit tog);
    int rem, pos, chunk, npk;
    bit t;
    logic [15:0] c;
    logic [63:0] w;
    logic [7:0]  b;
    exp_b.delete(); exp_sop.delete(); exp_eop.delete();
    npk = (len == 0) ? 1 : (len + MAXP - 1) / MAXP;
`ifdef USB_PKT_ZLP_EN
    if (len != 0 && len % MAXP == 0) npk++;
`endif
    rem = len; pos = 0; t = tog;
    for (int p = 0; p < npk; p++) begin
      chunk = (rem > MAXP) ? MAXP : rem;
      push_exp(t ? 8'h4B : 8'hC3, 1'b1, 1'b0);
      c = 16'hFFFF;
      for (int k = 0; k < chunk; k++) begin
        w = words_all[pos / 8];
        b = w[8 * (pos % 8) +: 8];
        c = crc_step(c, b);
        push_exp(b, 1'b0, 1'b0);
        pos++;
      end
      push_exp(~c[7:0], 1'b0, 1'b0);
      push_exp(~c[15:8], 1'b0, 1'b1);
      rem -= chunk;
      t = ~t;
    end
    exp_pkts = npk;
    exp_nt = t;
  endtask

  function automatic int first_diff();
    int n;
    n = (obs_b.size() < exp_b.size()) ? obs_b.size() : exp_b.size();
    for (int k = 0; k < n; k++) begin
      if (obs_b[k] !== exp_b[k] || obs_sop[k] !== exp_sop[k] || obs_eop[k] !== exp_eop[k]) return k;
    end
    if (obs_b.size() != exp_b.size()) return n;
    return -1;
  endfunction

  task automatic start_xfer(input int len, input bit tog, input bit fixed);
    logic [63:0] w;
    words_all.delete();
    wq.delete();
    for (int i = 0; i < (len + 7) / 8; i++) begin
      w = fixed ? 64'h0706050403020100 : {$urandom, $urandom};
      words_all.push_back(w);
      wq.push_back(w);
    end
    build_expected(len, tog);
    obs_b.delete(); obs_sop.delete(); obs_eop.delete();
    words_read = 0;
    stall_viol = 0;
    for (int i = 0; i < 200 && !o_desc_ready; i++) @(negedge clk);
    @(negedge clk);
    desc_valid  = 1'b1;
    desc_length = 16'(len);
    desc_toggle = tog;
    @(negedge clk);
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int cyc;
    cyc = 0;
    while (done_cnt == base && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if ({o_desc_ready, o_busy, o_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: {desc_ready,busy,done}=%b required 100", {o_desc_ready, o_busy, o_done});
    end
    n_cmp++;
    if ({o_tx_valid, o_tx_sop, o_tx_eop, o_in_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_stream: {tx_valid,sop,eop,in_ready}=%b required 0000", {o_tx_valid, o_tx_sop, o_tx_eop, o_in_ready});
    end
    n_cmp++;
    if ({o_tx_data, o_pkt_count, o_next_toggle} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_values: tx_data=%h pkt_count=%0d next_toggle=%b required all 0", o_tx_data, o_pkt_count, o_next_toggle);
    end
    rst = 1'b0;
  endtask

  task automatic test_zlp();
    int base, d;
    base = done_cnt;
    start_xfer(0, 1'b0, 1'b0);
    wait_done(base);
    d = first_diff();
    n_cmp++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL zlp_stream: diff at byte %0d got %0d bytes required %0d", d, obs_b.size(), exp_b.size());
    end
    n_cmp++;
    if (obs_b.size() != 3 || {obs_b[0], obs_b[1], obs_b[2]} !== 24'hC30000 ||
        {obs_sop[0], obs_eop[0], obs_sop[2], obs_eop[2]} !== 4'b1001) begin
      n_fail++;
      $display("FAIL zlp_bytes: got %0d bytes first=%h required C3,00,00 with sop/eop framing", obs_b.size(), obs_b[0]);
    end
    n_cmp++;
    if ({o_next_toggle, o_pkt_count} !== {1'b1, 16'd1} || done_cnt !== base + 1 || words_read !== 0) begin
      n_fail++;
      $display("FAIL zlp_status: next_toggle=%b pkt_count=%0d dones=%0d words=%0d required 1,1,1,0",
               o_next_toggle, o_pkt_count, done_cnt - base, words_read);
    end
    last_nt = 1'b1;
  endtask

  task automatic test_short();
    int base, d;
    base = done_cnt;
    start_xfer(4, 1'b1, 1'b1);
    wait_done(base);
    d = first_diff();
    n_cmp++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL short_stream: diff at byte %0d got %0d bytes required %0d", d, obs_b.size(), exp_b.size());
    end
    n_cmp++;
    if (obs_b.size() != 7 || {obs_b[0], obs_b[1], obs_b[2], obs_b[3], obs_b[4]} !== 40'h4B00010203) begin
      n_fail++;
      $display("FAIL short_head: got %0d bytes pid=%h required 4B,00,01,02,03 + crc", obs_b.size(), obs_b[0]);
    end
    n_cmp++;
    if (words_read !== 1 || o_next_toggle !== 1'b0 || o_pkt_count !== 16'd1) begin
      n_fail++;
      $display("FAIL short_status: words=%0d next_toggle=%b pkt_count=%0d required 1,0,1", words_read, o_next_toggle, o_pkt_count);
    end
    last_nt = 1'b0;
  endtask

  task automatic test_multi_packet();
    int base, d;
    logic [23:0] pids;
    base = done_cnt;
    start_xfer(1030, 1'b0, 1'b0);
    wait_done(base);
    d = first_diff();
    n_cmp++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL multi_stream: diff at byte %0d got %0d bytes required %0d", d, obs_b.size(), exp_b.size());
    end
    pids = '0;
    for (int k = 0; k < obs_b.size(); k++) if (obs_sop[k]) pids = {pids[15:0], obs_b[k]};
    n_cmp++;
    if (pids !== 24'hC34BC3) begin
      n_fail++;
      $display("FAIL multi_pids: got %h required C34BC3", pids);
    end
    n_cmp++;
    if (o_pkt_count !== 16'd3 || words_read !== 129 || o_next_toggle !== 1'b1) begin
      n_fail++;
      $display("FAIL multi_status: pkt_count=%0d words=%0d next_toggle=%b required 3,129,1", o_pkt_count, words_read, o_next_toggle);
    end
    last_nt = 1'b1;
  endtask

  task automatic test_exact_multiple();
    int base, d, req_pkts;
    bit req_nt;
    req_pkts = 2;
    req_nt = 1'b0;
`ifdef USB_PKT_ZLP_EN
    req_pkts = 3;
    req_nt = 1'b1;
`endif
    base = done_cnt;
    start_xfer(1024, 1'b0, 1'b0);
    wait_done(base);
    d = first_diff();
    n_cmp++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL exact_stream: diff at byte %0d got %0d bytes required %0d", d, obs_b.size(), exp_b.size());
    end
    n_cmp++;
    if (o_pkt_count !== 16'(req_pkts) || words_read !== 128 || o_next_toggle !== req_nt) begin
      n_fail++;
      $display("FAIL exact_status: pkt_count=%0d words=%0d next_toggle=%b required %0d,128,%b",
               o_pkt_count, words_read, o_next_toggle, req_pkts, req_nt);
    end
    last_nt = req_nt;
  endtask

  task automatic test_backpressure();
    int base, d, len;
    bit tog;
    rnd_ready = 1'b1;
    rnd_gaps  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 1100);
      tog = 1'($urandom_range(0, 1));
      base = done_cnt;
      start_xfer(len, tog, 1'b0);
      wait_done(base);
      d = first_diff();
      n_cmp++;
      if (d !== -1) begin
        n_fail++;
        $display("FAIL bp_stream len=%0d: diff at byte %0d got %0d bytes required %0d", len, d, obs_b.size(), exp_b.size());
      end
      n_cmp++;
      if (stall_viol !== 0 || words_read !== (len + 7) / 8 || o_pkt_count !== 16'(exp_pkts) || o_next_toggle !== exp_nt) begin
        n_fail++;
        $display("FAIL bp_status len=%0d: stalls_broken=%0d words=%0d pkts=%0d nt=%b required 0,%0d,%0d,%b",
                 len, stall_viol, words_read, o_pkt_count, o_next_toggle, (len + 7) / 8, exp_pkts, exp_nt);
      end
      last_nt = exp_nt;
    end
    rnd_ready = 1'b0;
    rnd_gaps  = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base, d, len;
    bit nt1;
    len = $urandom_range(9, 40);
    base = done_cnt;
    start_xfer(len, 1'b0, 1'b0);
    wait_done(base);
    nt1 = exp_nt;
    n_cmp++;
    if (o_next_toggle !== nt1) begin
      n_fail++;
      $display("FAIL b2b_toggle: next_toggle=%b required %b", o_next_toggle, nt1);
    end
    base = done_cnt;
    start_xfer(len + 520, nt1, 1'b0);
    wait_done(base);
    d = first_diff();
    n_cmp++;
    if (d !== -1 || o_pkt_count !== 16'(exp_pkts)) begin
      n_fail++;
      $display("FAIL b2b_stream: diff at byte %0d pkts=%0d required no diff and %0d pkts", d, o_pkt_count, exp_pkts);
    end
    last_nt = exp_nt;
  endtask

  task automatic test_abort();
    int base, cyc, d;
    base = done_cnt;
    start_xfer(1030, 1'b0, 1'b0);
    cyc = 0;
    while (obs_b.size() < 536 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #2;
    wq.delete();
    n_cmp++;
    if ({o_tx_valid, o_in_ready, o_busy, o_desc_ready} !== 4'b0001 || obs_b.size() < 536) begin
      n_fail++;
      $display("FAIL abort_state: {tx_valid,in_ready,busy,desc_ready}=%b bytes=%0d required 0001 after >=536 bytes",
               {o_tx_valid, o_in_ready, o_busy, o_desc_ready}, obs_b.size());
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (done_cnt !== base || o_next_toggle !== last_nt) begin
      n_fail++;
      $display("FAIL abort_quiet: dones=%0d next_toggle=%b required 0,%b", done_cnt - base, o_next_toggle, last_nt);
    end
    base = done_cnt;
    start_xfer(10, 1'b1, 1'b0);
    wait_done(base);
    d = first_diff();
    n_cmp++;
    if (d !== -1 || obs_b[0] !== 8'h4B) begin
      n_fail++;
      $display("FAIL abort_resume: diff at byte %0d pid=%h required no diff and pid 4B", d, obs_b[0]);
    end
  endtask

  initial begin
    done_cnt = 0;
    words_read = 0;
    stall_viol = 0;
    test_reset();
    test_zlp();
    test_short();
    test_multi_packet();
    test_exact_multiple();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
